// File: rtl/decoder_2x4_pulse_if.sv
// Code input channel for decoder_2x4_pulse.
// Producer drives i/in_valid, the decoder returns in_ready.
interface decoder_2x4_pulse_if;
    logic [1:0] i;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output i,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  i,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/decoder_2x4_pulse.sv
// 2-bit code to timed one-hot strobe decoder.
// 2-entry input FIFO feeds an IDLE/HOLD/GAP pulse FSM.
module decoder_2x4_pulse #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    decoder_2x4_pulse_if.slave         in_if,
    output logic [3:0]                 y,
    output logic                       y_valid,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
    localparam logic [7:0] GAP_M1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam bit         HAS_GAP = (GAP > 0);

    logic [1:0] r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_y;

    logic       w_push;
    logic       w_pop;
    logic       w_avail;
    logic       w_cnt_zero;
    logic [1:0] w_head;
    logic [3:0] w_dec;

    assign in_if.in_ready = (r_count != 2'd2);
    assign w_push     = in_if.in_valid && in_if.in_ready;
    assign w_avail    = en && (r_count != 2'd0);
    assign w_cnt_zero = (r_cnt == 8'd0);
    assign w_head     = r_mem[r_rptr];
    assign w_dec      = 4'b0001 << w_head;

    // Pop the head whenever the FSM is about to start a new pulse
    always_comb begin
        w_pop = 1'b0;
        unique case (r_state)
            S_IDLE:  w_pop = w_avail;
            S_HOLD:  w_pop = w_cnt_zero && !HAS_GAP && w_avail;
            S_GAP:   w_pop = w_cnt_zero && w_avail;
            default: w_pop = 1'b0;
        endcase
    end

    // Two-entry FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= 2'd0;
            r_mem[1] <= 2'd0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= in_if.i;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Pulse FSM: load, hold for HOLD cycles, then GAP zero cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_y     <= 4'b0000;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_y     <= w_dec;
                        r_cnt   <= HOLD_M1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (HAS_GAP) begin
                        r_y     <= 4'b0000;
                        r_cnt   <= GAP_M1;
                        r_state <= S_GAP;
                    end else if (w_pop) begin
                        r_y   <= w_dec;
                        r_cnt <= HOLD_M1;
                    end else begin
                        r_y     <= 4'b0000;
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (w_pop) begin
                        r_y     <= w_dec;
                        r_cnt   <= HOLD_M1;
                        r_state <= S_HOLD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_y     <= 4'b0000;
                    r_cnt   <= 8'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign y       = r_y;
    assign y_valid = (r_state == S_HOLD);
    assign busy    = (r_state != S_IDLE);

endmodule
